// File: rtl/vga_timing_gen_if.sv
//==============================================================================
// Module      : vga_intf
// Description : VGA timing/pixel bundle passed along the overlay pipeline.
//               The timing source drives the out modport; draw stages take in.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vga_intf;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing source. Produces registered counts, syncs,
//               blanking, base rgb, frame/line strobes and a frame counter.
//               All flags are decoded from the next-count values so that every
//               signal presented in a cycle describes the same pixel.
//               Optional macro VGA_TIMING_TEST_PATTERN_EN: when defined, the
//               visible area shows eight vertical colour bars; otherwise
//               visible rgb is black and the next stage supplies background.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int   H_ACTIVE  = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        resync,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_cnt,
    vga_intf.out        vga_out
);

    localparam logic [10:0] c_H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int          c_BAR_W      = H_ACTIVE / 8;
`endif

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic [11:0] r_rgb;
    logic        r_frame_start;
    logic        r_line_start;
    logic [15:0] r_frame_cnt;

    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;
    logic        w_frame_inc;
    logic        w_hsync_nxt;
    logic        w_vsync_nxt;
    logic        w_hblnk_nxt;
    logic        w_vblnk_nxt;
    logic [11:0] w_rgb_nxt;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0]  w_bar;
`endif

    // Next raster position: resync jumps to the origin, otherwise advance when enabled
    always_comb begin
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        w_frame_inc  = 1'b0;
        if (resync) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = '0;
        end else if (en) begin
            if (r_hcount == c_H_LAST) begin
                w_hcount_nxt = '0;
                if (r_vcount == c_V_LAST) begin
                    w_vcount_nxt = '0;
                    w_frame_inc  = 1'b1;
                end else begin
                    w_vcount_nxt = r_vcount + 11'd1;
                end
            end else begin
                w_hcount_nxt = r_hcount + 11'd1;
            end
        end
    end

    // Decode syncs, blanking and base colour from the next position
    always_comb begin
        w_hblnk_nxt = (w_hcount_nxt >= c_H_ACT);
        w_vblnk_nxt = (w_vcount_nxt >= c_V_ACT);
        w_hsync_nxt = ((w_hcount_nxt >= c_HS_START) && (w_hcount_nxt < c_HS_END))
                      ? HSYNC_POL : ~HSYNC_POL;
        w_vsync_nxt = ((w_vcount_nxt >= c_VS_START) && (w_vcount_nxt < c_VS_END))
                      ? VSYNC_POL : ~VSYNC_POL;
        w_rgb_nxt   = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        // Bar index is the number of bar boundaries at or left of the pixel;
        // bit 2/1/0 of the index select the red/green/blue nibble.
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(w_hcount_nxt) >= i * c_BAR_W) begin
                w_bar = 3'(i);
            end
        end
        if (!w_hblnk_nxt && !w_vblnk_nxt) begin
            w_rgb_nxt = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
        end
`endif
    end

    // Output registers: update on enable or resync, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_rgb         <= 12'h000;
            r_frame_start <= 1'b1;
            r_line_start  <= 1'b1;
            r_frame_cnt   <= '0;
        end else if (resync || en) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_hblnk       <= w_hblnk_nxt;
            r_vblnk       <= w_vblnk_nxt;
            r_rgb         <= w_rgb_nxt;
            r_frame_start <= (w_hcount_nxt == 11'd0) && (w_vcount_nxt == 11'd0);
            r_line_start  <= (w_hcount_nxt == 11'd0);
            r_frame_cnt   <= r_frame_cnt + {15'd0, w_frame_inc};
        end
    end

    assign vga_out.hcount = r_hcount;
    assign vga_out.vcount = r_vcount;
    assign vga_out.hsync  = r_hsync;
    assign vga_out.vsync  = r_vsync;
    assign vga_out.hblnk  = r_hblnk;
    assign vga_out.vblnk  = r_vblnk;
    assign vga_out.rgb    = r_rgb;
    assign frame_start    = r_frame_start;
    assign line_start     = r_line_start;
    assign frame_cnt      = r_frame_cnt;

endmodule

`default_nettype wire
